regbus_master: RTL and testbench

- Initiator for the 4-entry 8-bit register file bus (address / write_en / read_en / data_in / read_data).
- Accepts single commands from a host-side valid/ready channel and sequences the bus strobes.
- Captures registered read data after a fixed latency and returns a response on a second valid/ready channel.
- Sits between the command decoder (UART/debug bridge) and the device register blocks.

---
 rtl/regbus_master_if.sv | 38 +++
 rtl/regbus_master.sv | 209 ++++++++++++++++++++
 tb/tb_regbus_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbus_master_if.sv
// Host command/response channels and register-bus strobes for regbus_master, grouped as one bundle.
// master = initiator view (regbus_master), slave = host plus device view (testbench or wrapper).
interface regbus_master_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] cmd_mask;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0] bus_address;
   logic              bus_write_en;
   logic              bus_read_en;
   logic [DATA_W-1:0] bus_data_out;
   logic [DATA_W-1:0] bus_read_data;

   logic              busy;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, bus_read_data,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             bus_address, bus_write_en, bus_read_en, bus_data_out, busy
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, bus_read_data,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             bus_address, bus_write_en, bus_read_en, bus_data_out, busy
   );
endinterface

// File: rtl/regbus_master.sv
// Single-outstanding register-bus initiator; read-modify-write (op 10) exists only with REGBUS_MASTER_RMW_EN.
// Accept->rsp_valid: err 1, wr 2, rd 2+READ_LAT, rmw 3+READ_LAT cycles; response held until rsp_ready, cmd_ready low while busy.
module regbus_master #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int READ_LAT = 1
) (
   input  logic            clk,
   input  logic            resetb,
   regbus_master_if.master bif
);

   localparam int              CNT_W      = 2;
   localparam logic [ADDR_W:0] NUM_REGS_X = NUM_REGS[ADDR_W:0];
   localparam logic [1:0]      OP_RD      = 2'b00;
   localparam logic [1:0]      OP_WR      = 2'b01;
   localparam logic [1:0]      OP_RMW     = 2'b10;
   localparam logic [1:0]      OP_RSV     = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ISSUE,
      RD_WAIT,
      RESP
`ifdef REGBUS_MASTER_RMW_EN
      , RMW_WR
`endif
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic              busy_q, busy_d;
   logic              cmd_bad;

`ifdef REGBUS_MASTER_RMW_EN
   typedef struct packed {
      logic              rmw;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] mask;
   } rmw_t;

   rmw_t              rmw_q, rmw_d;
   logic [DATA_W-1:0] old_q, old_d;
`else
   logic unused_mask;
   assign unused_mask = ^bif.cmd_mask;
`endif

   always_comb begin
      cmd_bad = ({1'b0, bif.cmd_addr} >= NUM_REGS_X) || (bif.cmd_op == OP_RSV);
`ifndef REGBUS_MASTER_RMW_EN
      if (bif.cmd_op == OP_RMW) cmd_bad = 1'b1;
`endif
   end

   always_comb begin
      state_nxt   = state;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
`ifdef REGBUS_MASTER_RMW_EN
      rmw_d       = rmw_q;
      old_d       = old_q;
`endif
      case (state)
         IDLE: begin
            if (bif.cmd_valid) begin
               cmd_ready_d = 1'b0;
               if (cmd_bad) begin
                  state_nxt   = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else if (bif.cmd_op == OP_WR) begin
                  state_nxt = WR;
                  addr_d    = bif.cmd_addr;
                  dout_d    = bif.cmd_wdata;
                  we_d      = 1'b1;
               end else begin
                  state_nxt = RD_ISSUE;
                  addr_d    = bif.cmd_addr;
                  re_d      = 1'b1;
`ifdef REGBUS_MASTER_RMW_EN
                  rmw_d = '{rmw: (bif.cmd_op == OP_RMW), wdata: bif.cmd_wdata, mask: bif.cmd_mask};
`endif
               end
            end
         end
         WR: begin
            state_nxt   = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end
         RD_ISSUE: begin
            state_nxt = RD_WAIT;
            cnt_d     = CNT_W'(READ_LAT - 1);
         end
         RD_WAIT: begin
            // cnt_q reaches zero in the cycle the device's registered data is valid
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
`ifdef REGBUS_MASTER_RMW_EN
               if (rmw_q.rmw) begin
                  state_nxt = RMW_WR;
                  old_d     = bif.bus_read_data;
                  dout_d    = (bif.bus_read_data & ~rmw_q.mask) | (rmw_q.wdata & rmw_q.mask);
                  we_d      = 1'b1;
               end else
`endif
               begin
                  state_nxt   = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = bif.bus_read_data;
               end
            end
         end
`ifdef REGBUS_MASTER_RMW_EN
         RMW_WR: begin
            state_nxt   = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = old_q;
         end
`endif
         RESP: begin
            if (bif.rsp_ready) begin
               state_nxt   = IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetb) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         addr_q      <= '0;
         dout_q      <= '0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         busy_q      <= 1'b0;
`ifdef REGBUS_MASTER_RMW_EN
         rmw_q       <= '0;
         old_q       <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         we_q        <= we_d;
         re_q        <= re_d;
         busy_q      <= busy_d;
`ifdef REGBUS_MASTER_RMW_EN
         rmw_q       <= rmw_d;
         old_q       <= old_d;
`endif
      end
   end

   assign bif.cmd_ready    = cmd_ready_q;
   assign bif.rsp_valid    = rsp_valid_q;
   assign bif.rsp_err      = rsp_err_q;
   assign bif.rsp_rdata    = rsp_rdata_q;
   assign bif.bus_address  = addr_q;
   assign bif.bus_data_out = dout_q;
   assign bif.bus_write_en = we_q;
   assign bif.bus_read_en  = re_q;
   assign bif.busy         = busy_q;

endmodule

// File: tb/tb_regbus_master.sv
// Bench for regbus_master: one DUT at READ_LAT=1 and one at READ_LAT=3, each with a register-file model.
// A sel signal steers the shared host channel to one DUT; responses are checked against a scoreboard queue.
module tb_regbus_master;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RMW = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;
   localparam logic [25:0] RST_PACK = 26'h200_0000;

   logic clk = 1'b0;
   logic resetb;
   always #5 clk = ~clk;

   logic       sel;
   logic       cmd_valid, rsp_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata, cmd_mask;

   regbus_master_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
   regbus_master_if #(.ADDR_W(4), .DATA_W(8)) b3 ();

   regbus_master #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(4), .READ_LAT(1)) dut1 (
      .clk(clk), .resetb(resetb), .bif(b1));
   regbus_master #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(4), .READ_LAT(3)) dut3 (
      .clk(clk), .resetb(resetb), .bif(b3));

   assign b1.cmd_valid = cmd_valid & ~sel;
   assign b3.cmd_valid = cmd_valid & sel;
   assign b1.cmd_op = cmd_op;       assign b3.cmd_op = cmd_op;
   assign b1.cmd_addr = cmd_addr;   assign b3.cmd_addr = cmd_addr;
   assign b1.cmd_wdata = cmd_wdata; assign b3.cmd_wdata = cmd_wdata;
   assign b1.cmd_mask = cmd_mask;   assign b3.cmd_mask = cmd_mask;
   assign b1.rsp_ready = rsp_ready; assign b3.rsp_ready = rsp_ready;

   // Register-file models: reads return data READ_LAT cycles after the read_en cycle, 8'hEE otherwise.
   logic [7:0] regs1 [16];
   logic [7:0] regs3 [16];
   logic [7:0] p1;
   logic [7:0] p3 [3];
   always @(posedge clk) begin
      if (b1.bus_write_en) regs1[b1.bus_address] <= b1.bus_data_out;
      if (b3.bus_write_en) regs3[b3.bus_address] <= b3.bus_data_out;
      p1    <= b1.bus_read_en ? regs1[b1.bus_address] : 8'hEE;
      p3[0] <= b3.bus_read_en ? regs3[b3.bus_address] : 8'hEE;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign b1.bus_read_data = p1;
   assign b3.bus_read_data = p3[2];

   logic       m_cmd_ready, m_rsp_valid, m_rsp_err, m_we, m_re, m_busy;
   logic [7:0] m_rsp_rdata, m_dout;
   logic [3:0] m_addr;
   assign m_cmd_ready = sel ? b3.cmd_ready    : b1.cmd_ready;
   assign m_rsp_valid = sel ? b3.rsp_valid    : b1.rsp_valid;
   assign m_rsp_err   = sel ? b3.rsp_err      : b1.rsp_err;
   assign m_rsp_rdata = sel ? b3.rsp_rdata    : b1.rsp_rdata;
   assign m_we        = sel ? b3.bus_write_en : b1.bus_write_en;
   assign m_re        = sel ? b3.bus_read_en  : b1.bus_read_en;
   assign m_addr      = sel ? b3.bus_address  : b1.bus_address;
   assign m_dout      = sel ? b3.bus_data_out : b1.bus_data_out;
   assign m_busy      = sel ? b3.busy         : b1.busy;

   typedef struct {
      logic       s;
      logic [1:0] op;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] mask;
      logic [7:0] exp_rdata;
      logic       exp_err;
      int         exp_lat;
      int         exp_wr;
      int         exp_rd;
      logic [3:0] exp_wa;
      logic [7:0] exp_wd;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   vec_t vecs [16];

   int n_cmp = 0, n_fail = 0;
   int cyc = 0;
   int wr_cnt = 0, rd_cnt = 0, both_bad = 0, rsp_cnt = 0, first_cnt = 0;
   logic       in_rsp = 1'b0, stab_bad = 1'b0;
   logic [7:0] cap_r;
   logic       cap_e;
   logic [3:0] last_wa;
   logic [7:0] last_wd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [25:0] pack_m();
      return {m_cmd_ready, m_rsp_valid, m_rsp_err, m_we, m_re, m_busy, m_addr, m_dout, m_rsp_rdata};
   endfunction

   function automatic vec_t mk(input logic s, input logic [1:0] op, input logic [3:0] addr,
                               input logic [7:0] wdata, input logic [7:0] mask,
                               input logic [7:0] er, input logic ee, input int el,
                               input int ew, input int erd, input logic [3:0] ewa, input logic [7:0] ewd);
      vec_t v;
      v.s = s; v.op = op; v.addr = addr; v.wdata = wdata; v.mask = mask;
      v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
      v.exp_wr = ew; v.exp_rd = erd; v.exp_wa = ewa; v.exp_wd = ewd;
      return v;
   endfunction

   // Strobe counters and response scoreboard, all sampled on the falling edge.
   always @(negedge clk) begin
      if (m_we) begin
         wr_cnt++;
         last_wa = m_addr;
         last_wd = m_dout;
      end
      if (m_re) rd_cnt++;
      if (m_we && m_re) both_bad++;
      if (m_rsp_valid) begin
         if (!in_rsp) begin
            in_rsp = 1'b1;
            first_cnt++;
            cap_r = m_rsp_rdata;
            cap_e = m_rsp_err;
            stab_bad = 1'b0;
            if (sb.size() == 0) begin
               check("unexpected_rsp", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_rdata", cap_r, mon_e.rdata);
               check("rsp_err", cap_e, mon_e.err);
               check("rsp_latency", cyc + 1 - mon_e.acc, mon_e.lat);
            end
         end else if (m_rsp_rdata !== cap_r || m_rsp_err !== cap_e) begin
            stab_bad = 1'b1;
         end
         if (rsp_ready) begin
            check("rsp_stable", stab_bad, 0);
            in_rsp = 1'b0;
            rsp_cnt++;
         end
      end else if (in_rsp) begin
         check("rsp_valid_held", m_rsp_valid, 1);
         in_rsp = 1'b0;
      end
   end

   task automatic run_cmd(input vec_t v, input int hold);
      int w0, r0, d0, t;
      logic bp;
      @(posedge clk); #1;
      sel = v.s;
      rsp_ready = (hold == 0);
      cmd_valid = 1'b1;
      cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_mask = v.mask;
      w0 = wr_cnt; r0 = rd_cnt; d0 = rsp_cnt;
      t = 0;
      @(negedge clk);
      while (!m_cmd_ready && t < 20) begin @(negedge clk); t++; end
      check("cmd_accept", m_cmd_ready, 1);
      sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, cyc + 1});
      @(posedge clk); #1;
      // keep cmd_valid high with junk while busy: it must be ignored
      cmd_op = 2'($urandom); cmd_addr = 4'($urandom);
      cmd_wdata = 8'($urandom); cmd_mask = 8'($urandom);
      t = 0;
      @(negedge clk);
      while (!m_rsp_valid && t < 20) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (hold > 0) begin
         bp = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            if (m_cmd_ready || !m_rsp_valid) bp = 1'b1;
         end
         check("bp_hold", bp, 0);
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         @(negedge clk);
         @(negedge clk);
         check("bp_release", {m_cmd_ready, m_rsp_valid}, 2'b10);
      end else begin
         t = 0;
         while (rsp_cnt == d0 && t < 20) begin @(negedge clk); t++; end
      end
      check("rsp_count", rsp_cnt - d0, 1);
      check("wr_strobes", wr_cnt - w0, v.exp_wr);
      check("rd_strobes", rd_cnt - r0, v.exp_rd);
      if (v.exp_wr > 0) check("wr_addr_data", {last_wa, last_wd}, {v.exp_wa, v.exp_wd});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, f0;
      vecs[0]  = mk(0, OP_WR,  4'd2,  8'hA5, 8'h00, 8'h00, 0, 2, 1, 0, 4'd2, 8'hA5);
      vecs[1]  = mk(0, OP_RD,  4'd2,  8'h00, 8'h00, 8'hA5, 0, 3, 0, 1, 4'd0, 8'h00);
      vecs[2]  = mk(0, OP_RD,  4'd7,  8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[3]  = mk(0, OP_RSV, 4'd1,  8'h11, 8'hFF, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[4]  = mk(0, OP_RD,  4'd4,  8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[5]  = mk(0, OP_WR,  4'd15, 8'h99, 8'h00, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[6]  = mk(0, OP_WR,  4'd0,  8'h3C, 8'h00, 8'h00, 0, 2, 1, 0, 4'd0, 8'h3C);
      vecs[7]  = mk(0, OP_RD,  4'd0,  8'h00, 8'h00, 8'h3C, 0, 3, 0, 1, 4'd0, 8'h00);
      vecs[8]  = mk(0, OP_WR,  4'd1,  8'hF0, 8'h00, 8'h00, 0, 2, 1, 0, 4'd1, 8'hF0);
`ifdef REGBUS_MASTER_RMW_EN
      vecs[9]  = mk(0, OP_RMW, 4'd1,  8'h0F, 8'h3C, 8'hF0, 0, 4, 1, 1, 4'd1, 8'hCC);
      vecs[10] = mk(0, OP_RD,  4'd1,  8'h00, 8'h00, 8'hCC, 0, 3, 0, 1, 4'd0, 8'h00);
`else
      vecs[9]  = mk(0, OP_RMW, 4'd1,  8'h0F, 8'h3C, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[10] = mk(0, OP_RD,  4'd1,  8'h00, 8'h00, 8'hF0, 0, 3, 0, 1, 4'd0, 8'h00);
`endif
      vecs[11] = mk(0, OP_RMW, 4'd9,  8'h0F, 8'h3C, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[12] = mk(1, OP_WR,  4'd3,  8'h5A, 8'h00, 8'h00, 0, 2, 1, 0, 4'd3, 8'h5A);
      vecs[13] = mk(1, OP_RD,  4'd3,  8'h00, 8'h00, 8'h5A, 0, 5, 0, 1, 4'd0, 8'h00);
`ifdef REGBUS_MASTER_RMW_EN
      vecs[14] = mk(1, OP_RMW, 4'd3,  8'hFF, 8'h0F, 8'h5A, 0, 6, 1, 1, 4'd3, 8'h5F);
      vecs[15] = mk(1, OP_RD,  4'd3,  8'h00, 8'h00, 8'h5F, 0, 5, 0, 1, 4'd0, 8'h00);
`else
      vecs[14] = mk(1, OP_RMW, 4'd3,  8'hFF, 8'h0F, 8'h00, 1, 1, 0, 0, 4'd0, 8'h00);
      vecs[15] = mk(1, OP_RD,  4'd3,  8'h00, 8'h00, 8'h5A, 0, 5, 0, 1, 4'd0, 8'h00);
`endif

      resetb = 1'b0; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_lat1", pack_m(), RST_PACK);
      sel = 1'b1;
      #1;
      check("reset_outputs_lat3", pack_m(), RST_PACK);
      sel = 1'b0;
      @(posedge clk); #1;
      resetb = 1'b1;

      for (int i = 0; i < 11; i++) run_cmd(vecs[i], 0);
      run_cmd(mk(0, OP_RD, 4'd2, 8'h00, 8'h00, 8'hA5, 0, 3, 0, 1, 4'd0, 8'h00), 5);
      for (int i = 11; i < 16; i++) run_cmd(vecs[i], 0);

      // reset while the READ_LAT=3 master sits in RD_WAIT; no response may ever appear
      @(posedge clk); #1;
      sel = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RD; cmd_addr = 4'd3;
      t = 0;
      @(negedge clk);
      while (!m_cmd_ready && t < 20) begin @(negedge clk); t++; end
      check("rst_seq_accept", m_cmd_ready, 1);
      f0 = first_cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      resetb = 1'b0;
      @(negedge clk);
      check("busy_before_reset", m_busy, 1);
      @(posedge clk);
      @(negedge clk);
      check("reset_mid_read", pack_m(), RST_PACK);
      @(posedge clk); #1;
      resetb = 1'b1;
      repeat (10) @(negedge clk);
      check("no_rsp_after_reset", first_cnt - f0, 0);

      run_cmd(mk(1, OP_WR, 4'd0, 8'h77, 8'h00, 8'h00, 0, 2, 1, 0, 4'd0, 8'h77), 0);
      run_cmd(mk(1, OP_RD, 4'd0, 8'h00, 8'h00, 8'h77, 0, 5, 0, 1, 4'd0, 8'h00), 0);

      check("scoreboard_empty", sb.size(), 0);
      check("both_strobes", both_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
